// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The LSB-first datapath and its start/done controller both import this package.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bit-counter width; it is never narrower than one bit, even for tiny operands.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, d = a - b - bin, with the borrow out in bout.
// The serial subtractor uses a single instance of it, once per clock cycle.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor that computes diff = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// It sits behind a start/done handshake and takes WIDTH SHIFT cycles plus one FINISH cycle per operation.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [WIDTH-1:0] sa_d, sb_d, res_d;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q, busy_q, done_q, borrow_out_q;
    logic             bit_d, bit_bout;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    sa_q     <= sa_d;
                    sb_q     <= sb_d;
                    res_q    <= res_d;
                    borrow_q <= bit_bout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Publish results from the final bit's combinational outputs, so they are visible in FINISH.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        diff_q       <= res_d;
                        borrow_out_q <= bit_bout;
                        state_q      <= FINISH;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8, plus an exhaustive check of full_subtractor.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       br;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    logic fs_a = 1'b0, fs_b = 1'b0, fs_bin = 1'b0, fs_d, fs_bout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    logic [7:0] hold_diff = '0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    full_subtractor u_fs (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result monitor: pops one expectation per done pulse
    always @(posedge clk) begin
        #1;
        if (rst_n && done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.br));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
                hold_diff = e.d;
            end
        end
    end

    // Drive a start from idle; returns after the accepting edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        start = 1'b1; a = av; b = bv;
        e.d = av - bv; e.br = (av < bv); e.cyc = cyc + 9;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        chk("busy_on", 32'(busy), 32'd1);
        chk("hold", 32'(diff), 32'(hold_diff));
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
        start_op(av, bv);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("busy_shift", 32'(busy), 32'd1);
            chk("hold", 32'(diff), 32'(hold_diff));
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        // Exhaustive full_subtractor against arithmetic a - b - bin
        for (int i = 0; i < 8; i++) begin
            int r;
            fs_a = i[2]; fs_b = i[1]; fs_bin = i[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            chk("fs_d", 32'(fs_d), 32'(r & 1));
            chk("fs_bout", 32'(fs_bout), 32'(r < 0));
        end

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h35, 8'h12);
        run_op(8'h00, 8'h01);
        run_op(8'hFF, 8'hFF);
        drain();

        // A start during busy must be ignored.
        start_op(8'h40, 8'h0A);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("busy_ign", 32'(busy), 32'd1);
            start = (i == 2); a = 8'h77; b = 8'h00;
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        drain();

        // Back-to-back: start held through the done cycle
        begin
            exp_t e;
            start = 1'b1; a = 8'h10; b = 8'h20;
            e.d = 8'hF0; e.br = 1'b1; e.cyc = cyc + 9;
            q.push_back(e);
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                chk("busy_b2b", 32'(busy), 32'd1);
            end
            e.cyc = cyc + 10;
            q.push_back(e);
            @(posedge clk); #1;
            chk("done_b2b", 32'(done), 32'd1);
            @(posedge clk); #1;
            chk("no_gap", 32'(busy), 32'd1);
            start = 1'b0;
            drain();
        end

        // Reset mid-operation
        start_op(8'h55, 8'h0F);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        q.delete();
        hold_diff = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        run_op(8'h80, 8'h7F);
        for (int i = 0; i < 4; i++) run_op(8'($urandom), 8'($urandom));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
